mips_register_file: RTL and testbench

- 32 x 32-bit general-purpose register file plus a HI/LO register pair for the single-cycle MIPS datapath.
- Sits directly upstream of the ALU. read_data1 and read_data2 drive the ALU operand inputs data1 and data2.
- The writeback path (ALU result or memory load data) returns through the write port.
- Provides write-through bypass, a hardwired-zero r0, a debug read port and a committed-write counter.

---
 rtl/mips_register_file.sv | 81 ++++++++
 tb/tb_mips_register_file.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mips_register_file.sv
// 32xDATA_W GPR file with HI/LO pair, write-through bypass, hardwired r0, debug port and write counter.
// Reads are combinational with zero latency; writes commit on the clock edge; the file never stalls.
module mips_register_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  input  logic              reg_write,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              hilo_write,
  input  logic [DATA_W-1:0] hi_in,
  input  logic [DATA_W-1:0] lo_in,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [CNT_W-1:0]  write_count
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DATA_W-1:0] hi_q;
  logic [DATA_W-1:0] lo_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              commit;

  // Gating with rst_n keeps the bypass from leaking write_data onto the read ports during reset.
  assign commit = rst_n && reg_write && (write_reg != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (commit) begin
        regs[write_reg] <= write_data;
        if (cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
      end
      if (hilo_write) begin
        hi_q <= hi_in;
        lo_q <= lo_in;
      end
    end
  end

  always_comb begin
    read_data1 = regs[read_reg1];
    if (read_reg1 == '0) read_data1 = '0;
    else if (commit && (write_reg == read_reg1)) read_data1 = write_data;
  end

  always_comb begin
    read_data2 = regs[read_reg2];
    if (read_reg2 == '0) read_data2 = '0;
    else if (commit && (write_reg == read_reg2)) read_data2 = write_data;
  end

  always_comb begin
    dbg_data = regs[dbg_addr];
    if (dbg_addr == '0) dbg_data = '0;
  end

  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign write_count = cnt_q;

  // An X here would make the write decision ambiguous for the whole file.
  a_no_x_we: assert property (@(posedge clk) disable iff (!rst_n)
                              !$isunknown({reg_write, hilo_write}));

endmodule

// File: tb/tb_mips_register_file.sv
// Bench for mips_register_file: vector table through a scoreboard queue, plus reset, HI/LO and saturation sequences.
module tb_mips_register_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  read_reg1, read_reg2, write_reg, dbg_addr;
  logic [31:0] read_data1, read_data2, write_data, hi_in, lo_in, hi_out, lo_out, dbg_data;
  logic        reg_write, hilo_write;
  logic [3:0]  write_count;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rw;
    logic [4:0]  wr;
    logic [31:0] wd;
    logic [4:0]  r1, r2, dbg;
    logic [31:0] e1, e2, edbg;
    logic [3:0]  ecnt;
  } vec_t;

  typedef struct {
    logic [31:0] e1, e2, edbg;
    logic [3:0]  ecnt;
  } exp_t;

  vec_t vt[10];
  exp_t sb[$];

  always #5 clk = ~clk;

  mips_register_file #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .read_reg1(read_reg1), .read_reg2(read_reg2),
    .read_data1(read_data1), .read_data2(read_data2),
    .reg_write(reg_write), .write_reg(write_reg), .write_data(write_data),
    .hilo_write(hilo_write), .hi_in(hi_in), .lo_in(lo_in),
    .hi_out(hi_out), .lo_out(lo_out),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .write_count(write_count)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    exp_t e;
    rst_n = 1'b0;
    read_reg1 = 5'd0; read_reg2 = 5'd0; dbg_addr = 5'd0;
    reg_write = 1'b0; write_reg = 5'd0; write_data = 32'h0;
    hilo_write = 1'b0; hi_in = 32'h0; lo_in = 32'h0;

    //             rw    wr     wd             r1     r2     dbg    e1             e2             edbg           cnt
    vt[0] = '{1'b1, 5'd3, 32'hDEADBEEF, 5'd3, 5'd4, 5'd3, 32'hDEADBEEF, 32'h0,        32'h0,        4'd0};
    vt[1] = '{1'b1, 5'd4, 32'h00000010, 5'd3, 5'd4, 5'd3, 32'hDEADBEEF, 32'h10,       32'hDEADBEEF, 4'd1};
    vt[2] = '{1'b0, 5'd0, 32'h0,        5'd3, 5'd4, 5'd4, 32'hDEADBEEF, 32'h10,       32'h10,       4'd2};
    vt[3] = '{1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd3, 5'd0, 32'h0,        32'hDEADBEEF, 32'h0,        4'd2};
    vt[4] = '{1'b0, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        32'h0,        4'd2};
    vt[5] = '{1'b1, 5'd7, 32'h5,        5'd1, 5'd2, 5'd7, 32'h0,        32'h0,        32'h0,        4'd2};
    vt[6] = '{1'b1, 5'd7, 32'h9,        5'd7, 5'd7, 5'd7, 32'h9,        32'h9,        32'h5,        4'd3};
    vt[7] = '{1'b0, 5'd0, 32'h0,        5'd7, 5'd3, 5'd7, 32'h9,        32'hDEADBEEF, 32'h9,        4'd4};
    vt[8] = '{1'b1, 5'd5, 32'h1234,     5'd5, 5'd7, 5'd5, 32'h1234,     32'h9,        32'h0,        4'd4};
    vt[9] = '{1'b0, 5'd5, 32'hAAAA,     5'd5, 5'd4, 5'd5, 32'h1234,     32'h10,       32'h1234,     4'd5};

    #12;
    chk("reset_rd1", read_data1, 32'h0);
    chk("reset_hi", hi_out, 32'h0);
    chk("reset_cnt", {28'h0, write_count}, 32'h0);
    rst_n = 1'b1;
    next_cycle();

    for (int i = 0; i < 10; i++) begin
      reg_write = vt[i].rw; write_reg = vt[i].wr; write_data = vt[i].wd;
      read_reg1 = vt[i].r1; read_reg2 = vt[i].r2; dbg_addr = vt[i].dbg;
      sb.push_back('{vt[i].e1, vt[i].e2, vt[i].edbg, vt[i].ecnt});
      @(negedge clk);
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL vec%0d: scoreboard empty, got 1 entry required", i);
      end else begin
        e = sb.pop_front();
        chk($sformatf("vec%0d_rd1", i), read_data1, e.e1);
        chk($sformatf("vec%0d_rd2", i), read_data2, e.e2);
        chk($sformatf("vec%0d_dbg", i), dbg_data, e.edbg);
        chk($sformatf("vec%0d_cnt", i), {28'h0, write_count}, {28'h0, e.ecnt});
      end
      next_cycle();
    end

    // HI/LO together with a GPR write in the same cycle
    hilo_write = 1'b1; hi_in = 32'hA; lo_in = 32'hB;
    reg_write = 1'b1; write_reg = 5'd2; write_data = 32'hC; read_reg1 = 5'd2;
    @(negedge clk);
    chk("hilo_pre_hi", hi_out, 32'h0);
    chk("hilo_pre_lo", lo_out, 32'h0);
    next_cycle();
    hilo_write = 1'b0; hi_in = 32'hFF; lo_in = 32'hFF; reg_write = 1'b0;
    @(negedge clk);
    chk("hilo_hi", hi_out, 32'hA);
    chk("hilo_lo", lo_out, 32'hB);
    chk("hilo_r2", read_data1, 32'hC);
    chk("hilo_cnt", {28'h0, write_count}, 32'd6);
    next_cycle();
    chk("hilo_hold", hi_out, 32'hA);

    // Asynchronous reset between edges, with a write held across a reset edge
    hilo_write = 1'b1; hi_in = 32'h7;
    next_cycle();
    hilo_write = 1'b0; read_reg1 = 5'd5; dbg_addr = 5'd5; read_reg2 = 5'd6;
    @(negedge clk);
    chk("prerst_rd1", read_data1, 32'h1234);
    chk("prerst_hi", hi_out, 32'h7);
    #2;
    rst_n = 1'b0;
    reg_write = 1'b1; write_reg = 5'd6; write_data = 32'h55;
    #1;
    chk("arst_rd1", read_data1, 32'h0);
    chk("arst_hi", hi_out, 32'h0);
    chk("arst_cnt", {28'h0, write_count}, 32'h0);
    chk("arst_dbg", dbg_data, 32'h0);
    chk("arst_nobypass", read_data2, 32'h0);
    @(posedge clk);
    #2;
    reg_write = 1'b0; dbg_addr = 5'd6;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstedge_r6", dbg_data, 32'h0);
    chk("rstedge_cnt", {28'h0, write_count}, 32'h0);
    next_cycle();

    // Counter saturation at 15
    for (int k = 0; k < 20; k++) begin
      reg_write = 1'b1; write_reg = 5'((k % 31) + 1); write_data = 32'(k);
      next_cycle();
      if (k == 13) chk("sat_14", {28'h0, write_count}, 32'd14);
      if (k == 14) chk("sat_15", {28'h0, write_count}, 32'd15);
    end
    reg_write = 1'b0;
    @(negedge clk);
    chk("sat_hold", {28'h0, write_count}, 32'd15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
